// File: rtl/status_tag_queue_pkg.sv
// status_queue_pkg: shared sizing helpers, entry field layout and per-entry operation codes
package status_queue_pkg;
  localparam int VLD_OFS = 0;
  localparam int DONE_OFS = 1;
  localparam int TAG_OFS = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int val_ofs(input int tag_w);
    return TAG_OFS + tag_w;
  endfunction
  function automatic int ent_w(input int width, input int tag_w);
    return val_ofs(tag_w) + width;
  endfunction
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_SHIFT,
    OP_LOAD,
    OP_UPDATE,
    OP_SHIFT_UPDATE,
    OP_CLEAR
  } entry_op_e;
endpackage

// File: rtl/status_tag_queue_if.sv
// status_tag_queue_if: push/update/pull handshake and head/status bundle of the tag queue
interface status_tag_queue_if
  import status_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  localparam int CNT_W = cnt_w(DEPTH);
  logic             flush_i;
  logic             push_i;
  logic [TAG_W-1:0] push_tag_i;
  logic [WIDTH-1:0] push_value_i;
  logic             push_ready_o;
  logic             upd_i;
  logic [TAG_W-1:0] upd_tag_i;
  logic [WIDTH-1:0] upd_value_i;
  logic             upd_hit_o;
  logic             pull_i;
  logic             valid_o;
  logic             done_o;
  logic [WIDTH-1:0] value_o;
  logic [TAG_W-1:0] tag_o;
  logic [CNT_W-1:0] count_o;
  logic             empty_o;
  logic             full_o;
  logic             afull_o;
  modport master (
    output flush_i, push_i, push_tag_i, push_value_i, upd_i, upd_tag_i, upd_value_i, pull_i,
    input  push_ready_o, upd_hit_o, valid_o, done_o, value_o, tag_o, count_o, empty_o, full_o, afull_o
  );
  modport slave (
    input  flush_i, push_i, push_tag_i, push_value_i, upd_i, upd_tag_i, upd_value_i, pull_i,
    output push_ready_o, upd_hit_o, valid_o, done_o, value_o, tag_o, count_o, empty_o, full_o, afull_o
  );
endinterface

// File: rtl/status_tag_queue_entry.sv
// status_tag_entry: next-state mux for one queue slot {value, tag, done, valid}
module status_tag_entry
  import status_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  localparam int EW = ent_w(WIDTH, TAG_W)
) (
  input  entry_op_e         op_i,
  input  logic [EW-1:0]     cur_i,
  input  logic [EW-1:0]     up_i,
  input  logic [TAG_W-1:0]  push_tag_i,
  input  logic [WIDTH-1:0]  push_value_i,
  input  logic [WIDTH-1:0]  upd_value_i,
  output logic [EW-1:0]     nxt_o
);
  localparam int VO = val_ofs(TAG_W);
  logic shift;
  logic upd;
  always_comb begin
    shift = op_i == OP_SHIFT || op_i == OP_SHIFT_UPDATE;
    upd = op_i == OP_UPDATE || op_i == OP_SHIFT_UPDATE;
    nxt_o = shift ? up_i : cur_i;
    if (upd) begin
      nxt_o[DONE_OFS] = 1'b1;
      nxt_o[VO+:WIDTH] = upd_value_i;
    end
    if (op_i == OP_LOAD) nxt_o = {push_value_i, push_tag_i, 1'b0, 1'b1};
    if (op_i == OP_CLEAR) nxt_o = '0;
  end
endmodule

// File: rtl/status_tag_queue.sv
// status_tag_queue: in-order collapsing completion queue with tag-matched out-of-order updates
module status_tag_queue
  import status_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int AFULL_LVL = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  status_tag_queue_if.slave q
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int EW = ent_w(WIDTH, TAG_W);
  localparam int VO = val_ofs(TAG_W);
  logic [EW-1:0]    ent [DEPTH];
  logic [EW-1:0]    nxt [DEPTH];
  entry_op_e        op [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [CNT_W-1:0] count, cnt_nxt, ld_idx;
  logic             empty, full, afull;
  logic             pull_fire, push_fire;
  assign pull_fire = q.pull_i & ent[0][VLD_OFS] & ent[0][DONE_OFS];
  assign push_fire = q.push_i & (~full | pull_fire);
  assign ld_idx = pull_fire ? count - 1'b1 : count;
  assign cnt_nxt = q.flush_i ? '0 : count + CNT_W'(push_fire) - CNT_W'(pull_fire);
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [EW-1:0] up;
    logic          hit_up;
    if (i == DEPTH - 1) begin : g_top
      assign up = '0;
      assign hit_up = 1'b0;
    end else begin : g_mid
      assign up = ent[i+1];
      assign hit_up = hit[i+1];
    end
    assign hit[i] = q.upd_i & ent[i][VLD_OFS] & ~ent[i][DONE_OFS] & (ent[i][TAG_OFS+:TAG_W] == q.upd_tag_i);
    assign op[i] = q.flush_i ? OP_CLEAR :
                   (push_fire && ld_idx == CNT_W'(i)) ? OP_LOAD :
                   pull_fire ? (hit_up ? OP_SHIFT_UPDATE : OP_SHIFT) :
                   hit[i] ? OP_UPDATE : OP_HOLD;
    status_tag_entry #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_ent (
      .op_i        (op[i]),
      .cur_i       (ent[i]),
      .up_i        (up),
      .push_tag_i  (q.push_tag_i),
      .push_value_i(q.push_value_i),
      .upd_value_i (q.upd_value_i),
      .nxt_o       (nxt[i])
    );
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent <= '{default: '0};
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      afull <= 1'b0;
    end else begin
      ent <= nxt;
      count <= cnt_nxt;
      empty <= cnt_nxt == '0;
      full <= cnt_nxt == CNT_W'(DEPTH);
      afull <= cnt_nxt >= CNT_W'(AFULL_LVL);
    end
  end
  assign q.valid_o = ent[0][VLD_OFS];
  assign q.done_o = ent[0][DONE_OFS];
  assign q.tag_o = ent[0][TAG_OFS+:TAG_W];
  assign q.value_o = ent[0][VO+:WIDTH];
  assign q.count_o = count;
  assign q.empty_o = empty;
  assign q.full_o = full;
  assign q.afull_o = afull;
  assign q.push_ready_o = ~full;
  assign q.upd_hit_o = |hit;
endmodule
